// File: rtl/ecc_seq_pkg.sv
// Shared types and constants for the ECC APB sequencer: FSM states, ECC_ENC_DEC
// register map and command opcode encodings.
package ecc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        WAIT_DONE,
        RESP
    } seq_state_e;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_DATA_IN  = 8'h04;
    localparam logic [7:0] ADDR_CW_WIDTH = 8'h08;
    localparam logic [7:0] ADDR_NOISE    = 8'h0C;

    localparam logic [1:0] OP_ENCODE = 2'b00;
    localparam logic [1:0] OP_DECODE = 2'b01;
    localparam logic [1:0] OP_FULL   = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    // CTRL goes last because writing it is what kicks off the ECC operation.
    function automatic logic [7:0] wr_index_addr(input logic [1:0] idx);
        logic [7:0] addr;
        case (idx)
            2'd0:    addr = ADDR_DATA_IN;
            2'd1:    addr = ADDR_CW_WIDTH;
            2'd2:    addr = ADDR_NOISE;
            default: addr = ADDR_CTRL;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/ecc_apb_write_phy.sv
// Two-cycle APB write master: a wr_start pulse yields SETUP on the next cycle, then ACCESS.
// No wait states; back-to-back starts issued during ACCESS chain straight into SETUP.
module ecc_apb_write_phy #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_start,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE
);

    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;

    always_comb begin
        psel_d    = wr_start | (psel_q & ~penable_q);
        penable_d = psel_q & ~penable_q;
        pwrite_d  = psel_d;
        paddr_d   = '0;
        pwdata_d  = '0;
        if (wr_start) begin
            paddr_d  = wr_addr;
            pwdata_d = wr_data;
        end else if (psel_d) begin
            paddr_d  = paddr_q;
            pwdata_d = pwdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;

endmodule

// File: rtl/ecc_apb_sequencer.sv
// Programs ECC_ENC_DEC over APB (4 writes, 8 cycles), waits for operation_done, then holds
// the result on rsp_* until rsp_ready. ECC_SEQ_TIMEOUT_EN enables the WAIT_DONE watchdog.
module ecc_apb_sequencer
    import ecc_seq_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [AMBA_WORD-1:0]       cmd_data,
    input  logic [1:0]                 cmd_width,
    input  logic [AMBA_WORD-1:0]       cmd_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_errors,
    output logic                       rsp_timeout,
    output logic                       busy
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    seq_state_e                 state_q, state_d;
    logic [1:0]                 idx_q, idx_d;
    logic [1:0]                 op_q, op_d;
    logic [AMBA_WORD-1:0]       data_q, data_d;
    logic [1:0]                 width_q, width_d;
    logic [AMBA_WORD-1:0]       noise_q, noise_d;
    logic                       cmd_ready_q, cmd_ready_d;
    logic                       busy_q, busy_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]      rsp_data_q, rsp_data_d;
    logic [1:0]                 rsp_errors_q, rsp_errors_d;
    logic                       rsp_timeout_q, rsp_timeout_d;

    logic                       wr_start;
    logic [AMBA_ADDR_WIDTH-1:0] wr_addr;
    logic [AMBA_WORD-1:0]       wr_data;
    logic                       wait_expired;

`ifdef ECC_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign wait_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        op_d          = op_q;
        data_d        = data_q;
        width_d       = width_q;
        noise_d       = noise_q;
        rsp_data_d    = rsp_data_q;
        rsp_errors_d  = rsp_errors_q;
        rsp_timeout_d = rsp_timeout_q;
        wr_start      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    width_d = cmd_width;
                    noise_d = cmd_noise;
                    idx_d   = 2'd0;
                    if (cmd_op == OP_RSVD) begin
                        state_d       = RESP;
                        rsp_data_d    = '0;
                        rsp_errors_d  = 2'b11;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        state_d  = SETUP;
                        wr_start = 1'b1;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (idx_q == 2'd3) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d  = SETUP;
                    idx_d    = idx_q + 2'd1;
                    wr_start = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (operation_done) begin
                    state_d       = RESP;
                    rsp_data_d    = data_out;
                    rsp_errors_d  = num_of_errors;
                    rsp_timeout_d = 1'b0;
                end else if (wait_expired) begin
                    state_d       = RESP;
                    rsp_data_d    = '0;
                    rsp_errors_d  = 2'b11;
                    rsp_timeout_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    // Write payload follows the next index; on acceptance the *_d fields are the raw cmd inputs.
    always_comb begin
        wr_addr = AMBA_ADDR_WIDTH'(wr_index_addr(idx_d));
        case (idx_d)
            2'd0:    wr_data = data_d;
            2'd1:    wr_data = AMBA_WORD'(width_d);
            2'd2:    wr_data = noise_d;
            default: wr_data = AMBA_WORD'(op_d);
        endcase
    end

`ifdef ECC_SEQ_TIMEOUT_EN
    always_comb begin
        cnt_d = '0;
        if (state_q == WAIT_DONE && state_d == WAIT_DONE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            idx_q         <= 2'd0;
            op_q          <= 2'd0;
            data_q        <= '0;
            width_q       <= 2'd0;
            noise_q       <= '0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_errors_q  <= 2'd0;
            rsp_timeout_q <= 1'b0;
`ifdef ECC_SEQ_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            op_q          <= op_d;
            data_q        <= data_d;
            width_q       <= width_d;
            noise_q       <= noise_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_errors_q  <= rsp_errors_d;
            rsp_timeout_q <= rsp_timeout_d;
`ifdef ECC_SEQ_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    ecc_apb_write_phy #(
        .ADDR_W (AMBA_ADDR_WIDTH),
        .DATA_W (AMBA_WORD)
    ) u_write_phy (
        .clk      (clk),
        .rst      (rst),
        .wr_start (wr_start),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE)
    );

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_errors = rsp_errors_q;
`ifdef ECC_SEQ_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// Directed bench for ecc_apb_sequencer: encode, decode with backpressure, reserved op,
// reset during an APB access and (with ECC_SEQ_TIMEOUT_EN) the WAIT_DONE watchdog.
module tb_ecc_apb_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [1:0]  cmd_width;
    logic [31:0] cmd_noise;
    logic [19:0] PADDR;
    logic [31:0] PWDATA;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic        operation_done;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_errors;
    logic        rsp_timeout;
    logic        busy;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    ecc_apb_sequencer #(
        .DATA_WIDTH      (32),
        .AMBA_ADDR_WIDTH (20),
        .AMBA_WORD       (32),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_data       (cmd_data),
        .cmd_width      (cmd_width),
        .cmd_noise      (cmd_noise),
        .PADDR          (PADDR),
        .PWDATA         (PWDATA),
        .PSEL           (PSEL),
        .PENABLE        (PENABLE),
        .PWRITE         (PWRITE),
        .operation_done (operation_done),
        .data_out       (data_out),
        .num_of_errors  (num_of_errors),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_errors     (rsp_errors),
        .rsp_timeout    (rsp_timeout),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one non-reserved command and checks all eight APB cycles; returns in WAIT_DONE.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] d, input logic [1:0] w,
                           input logic [31:0] n, input bit stale);
        logic [19:0] ea [4];
        logic [31:0] ed [4];
        ea = '{20'h4, 20'h8, 20'hC, 20'h0};
        ed = '{d, {30'b0, w}, n, {30'b0, op}};
        chk("pre_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_width = w;
        cmd_noise = n;
        if (stale) begin
            operation_done = 1'b1;
            data_out       = 32'hDEAD_BEEF;
            num_of_errors  = 2'd2;
        end
        step();
        cmd_valid = 1'b0;
        chk("busy_in_setup", busy, 1);
        chk("cmd_ready_in_setup", cmd_ready, 0);
        for (int i = 0; i < 4; i++) begin
            chk("setup_psel", PSEL, 1);
            chk("setup_penable", PENABLE, 0);
            chk("setup_pwrite", PWRITE, 1);
            chk("setup_paddr", PADDR, ea[i]);
            chk("setup_pwdata", PWDATA, ed[i]);
            step();
            chk("access_psel", PSEL, 1);
            chk("access_penable", PENABLE, 1);
            chk("access_paddr", PADDR, ea[i]);
            chk("access_pwdata", PWDATA, ed[i]);
            step();
        end
        operation_done = 1'b0;
        chk("wait_psel", PSEL, 0);
        chk("wait_pwrite", PWRITE, 0);
        chk("wait_paddr", PADDR, 0);
        chk("wait_pwdata", PWDATA, 0);
        chk("wait_rsp_valid", rsp_valid, 0);
        chk("wait_busy", busy, 1);
    endtask

    initial begin
        rst            = 1'b0;
        cmd_valid      = 1'b0;
        cmd_op         = 2'b00;
        cmd_data       = '0;
        cmd_width      = 2'b00;
        cmd_noise      = '0;
        operation_done = 1'b0;
        data_out       = '0;
        num_of_errors  = 2'b00;
        rsp_ready      = 1'b0;
        step();
        step();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        rst = 1'b1;
        step();

        // Encode: operation_done on the third WAIT_DONE cycle.
        run_cmd(2'b00, 32'h0000_00A5, 2'd2, 32'h0, 1'b0);
        step();
        step();
        chk("enc_wait_rsp_valid", rsp_valid, 0);
        operation_done = 1'b1;
        data_out       = 32'h0000_0E5A;
        num_of_errors  = 2'd0;
        step();
        operation_done = 1'b0;
        chk("enc_rsp_valid", rsp_valid, 1);
        chk("enc_rsp_data", rsp_data, 32'h0000_0E5A);
        chk("enc_rsp_errors", rsp_errors, 0);
        chk("enc_rsp_timeout", rsp_timeout, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("enc_done_rsp_valid", rsp_valid, 0);
        chk("enc_done_cmd_ready", cmd_ready, 1);
        chk("enc_done_busy", busy, 0);

        // Decode with one flipped bit; stale operation_done is held during the writes.
        run_cmd(2'b01, 32'h0000_00A5, 2'd2, 32'h0000_0001, 1'b1);
        operation_done = 1'b1;
        data_out       = 32'h0000_00A5;
        num_of_errors  = 2'd1;
        step();
        chk("dec_rsp_valid", rsp_valid, 1);
        chk("dec_rsp_data", rsp_data, 32'h0000_00A5);
        chk("dec_rsp_errors", rsp_errors, 1);

        // Backpressure: rsp_* must hold while a reserved command waits on cmd_valid.
        data_out  = 32'hFFFF_FFFF;
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 32'h0000_00A5);
            chk("bp_rsp_errors", rsp_errors, 1);
            chk("bp_cmd_ready", cmd_ready, 0);
        end
        operation_done = 1'b0;
        rsp_ready      = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("hs_rsp_valid", rsp_valid, 0);
        chk("hs_cmd_ready", cmd_ready, 1);
        chk("hs_psel", PSEL, 0);

        // Reserved op is accepted on the next edge and answered without APB traffic.
        step();
        cmd_valid = 1'b0;
        chk("rsvd_psel", PSEL, 0);
        chk("rsvd_rsp_valid", rsp_valid, 1);
        chk("rsvd_rsp_errors", rsp_errors, 2'b11);
        chk("rsvd_rsp_data", rsp_data, 0);
        chk("rsvd_cmd_ready", cmd_ready, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsvd_done_cmd_ready", cmd_ready, 1);
        chk("rsvd_done_psel", PSEL, 0);

        // Reset asserted during ACCESS of write index 2.
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_data  = 32'h1234_5678;
        cmd_width = 2'd1;
        cmd_noise = 32'h0000_0100;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("mid_access_penable", PENABLE, 1);
        chk("mid_access_paddr", PADDR, 20'hC);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_psel", PSEL, 0);
        chk("midrst_penable", PENABLE, 0);
        chk("midrst_paddr", PADDR, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);

        // Full sequence again: index must restart at DATA_IN.
        run_cmd(2'b10, 32'h0000_5A5A, 2'd3, 32'h8000_0000, 1'b0);
        operation_done = 1'b1;
        data_out       = 32'h0000_5A5A;
        num_of_errors  = 2'd2;
        step();
        operation_done = 1'b0;
        chk("full_rsp_valid", rsp_valid, 1);
        chk("full_rsp_data", rsp_data, 32'h0000_5A5A);
        chk("full_rsp_errors", rsp_errors, 2);
        chk("full_rsp_timeout", rsp_timeout, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("full_done_cmd_ready", cmd_ready, 1);

`ifdef ECC_SEQ_TIMEOUT_EN
        // Watchdog: no operation_done, response exactly 16 cycles after entering WAIT_DONE.
        run_cmd(2'b00, 32'h0000_0011, 2'd0, 32'h0, 1'b1);
        for (int i = 0; i < 15; i++) step();
        chk("to_early_rsp_valid", rsp_valid, 0);
        chk("to_early_timeout", rsp_timeout, 0);
        step();
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_timeout", rsp_timeout, 1);
        chk("to_rsp_errors", rsp_errors, 2'b11);
        chk("to_rsp_data", rsp_data, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("to_done_cmd_ready", cmd_ready, 1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ecc_apb_sequencer.md
ECC_APB_SEQUENCER -- requirements
Module: ecc_apb_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the ECC data_out and rsp_data bus.
REQ-002 Parameter AMBA_ADDR_WIDTH, default 20, APB address width.
REQ-003 Parameter AMBA_WORD, default 32, APB data width and cmd_data/cmd_noise width.
REQ-004 Parameter TIMEOUT_CYCLES, default 64, WAIT_DONE watchdog limit (used only with ECC_SEQ_TIMEOUT_EN).
REQ-005 Port clk  in  1  single clock; all logic on rising edge.
REQ-006 Port rst  in  1  reset, synchronous, active-low.
REQ-007 Port cmd_valid  in  1  requester presents a command.
REQ-008 Port cmd_ready  out  1  sequencer accepts a command this cycle.
REQ-009 Port cmd_op  in  2  CTRL value: 00 encode, 01 decode, 10 full, 11 reserved.
REQ-010 Port cmd_data  in  AMBA_WORD  value for DATA_IN register.
REQ-011 Port cmd_width  in  2  value for CODEWORD_WIDTH register.
REQ-012 Port cmd_noise  in  AMBA_WORD  value for NOISE register.
REQ-013 Ports PADDR out AMBA_ADDR_WIDTH, PWDATA out AMBA_WORD, PSEL out 1, PENABLE out 1, PWRITE out 1  APB master toward ECC_ENC_DEC.
REQ-014 Ports operation_done in 1, data_out in DATA_WIDTH, num_of_errors in 2  ECC_ENC_DEC result.
REQ-015 Ports rsp_valid out 1, rsp_ready in 1, rsp_data out DATA_WIDTH, rsp_errors out 2, rsp_timeout out 1, busy out 1  result handshake to requester.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, ACCESS, WAIT_DONE, RESP.
REQ-017 cmd_ready SHALL be 1 only in IDLE; busy SHALL be 1 in every state except IDLE.
REQ-018 On cmd_valid&&cmd_ready, cmd fields SHALL be latched and FSM SHALL go to SETUP with write index 0.
REQ-019 Write sequence SHALL be fixed: DATA_IN @0x04, CODEWORD_WIDTH @0x08, NOISE @0x0C, CTRL @0x00 (CTRL last triggers operation).
REQ-020 SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR/PWDATA of current index; ACCESS: same with PENABLE=1; each write = exactly 2 cycles, no wait states.
REQ-021 After ACCESS, index<3 -> SETUP with index+1; index==3 -> WAIT_DONE; full sequence = 8 cycles.
REQ-022 Outside SETUP/ACCESS, PSEL=PENABLE=PWRITE=0 and PADDR/PWDATA=0.
REQ-023 operation_done SHALL be ignored outside WAIT_DONE.
REQ-024 In WAIT_DONE, operation_done=1 SHALL capture data_out->rsp_data, num_of_errors->rsp_errors, rsp_timeout=0, go to RESP next cycle.
REQ-025 In RESP, rsp_valid=1 with stable rsp_* until rsp_ready=1; on that edge -> IDLE, rsp_valid=0.
REQ-026 cmd_op=11 SHALL be accepted and skipped (no APB activity), go directly to RESP with rsp_data=0, rsp_errors=2'b11.
REQ-027 New command SHALL be accepted no earlier than the cycle after RESP handshake (no overlap).

Reset
REQ-028 rst==0 at a rising edge SHALL force IDLE, index 0, all outputs 0 except cmd_ready=1, regardless of current state, including mid-APB-transfer.

Configuration
REQ-029 Macro ECC_SEQ_TIMEOUT_EN defined: cycle counter in WAIT_DONE; after TIMEOUT_CYCLES cycles without operation_done -> RESP with rsp_timeout=1, rsp_data=0, rsp_errors=2'b11.
REQ-030 Macro undefined: no counter, WAIT_DONE waits indefinitely, rsp_timeout tied 0.

Structure
REQ-031 Package ecc_seq_pkg SHALL hold state enum, register address constants (0x00/0x04/0x08/0x0C), cmd_op encodings.
REQ-032 Sub-module ecc_apb_write_phy SHALL implement the 2-cycle SETUP/ACCESS write; top holds sequencing FSM.

Verification
REQ-033 Encode cmd (op=00, data=0x0000_00A5, width=2, noise=0) -> 8 APB cycles, addrs 0x04,0x08,0x0C,0x00; operation_done after 3 cycles -> rsp_valid 1 cycle later.
REQ-034 Decode with noise=0x0000_0001, ECC returns num_of_errors=1, data_out=0xA5 -> rsp_errors=1, rsp_data=0xA5.
REQ-035 rsp_ready held 0 for 5 cycles -> rsp_* stable, cmd_ready=0, second cmd_valid not accepted until after handshake.
REQ-036 rst=0 during ACCESS of write index 2 -> next cycle PSEL=0, PENABLE=0, cmd_ready=1, rsp_valid=0.
REQ-037 With ECC_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, no operation_done -> rsp_timeout=1 exactly 16 cycles after entering WAIT_DONE; stale operation_done during writes ignored.
REQ-038 cmd_op=11 -> no PSEL assertion, rsp_valid next cycle with rsp_errors=2'b11.
